// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types and constants for the FFT frame sequencer: state encoding,
// default frame/config values and the real-to-complex beat packing helper.
package fft_seq_pkg;

   localparam int FFT_FRAME_LEN = 512;
   localparam int FFT_SAMPLE_W  = 16;
   localparam int FFT_CHANNELS  = 4;
   localparam int FFT_CFG_W     = 16;

   localparam logic [FFT_CFG_W-1:0] FFT_CFG_DEFAULT = '0;

   typedef enum logic [2:0] {
      CFG,
      ARM,
      FILL,
      WAIT,
      DRAIN
   } fft_seq_state_t;

   // Each channel becomes {imag = 0, real = sample}, channel 0 in the LSBs.
   function automatic logic [FFT_CHANNELS*2*FFT_SAMPLE_W-1:0] packZeroImag(
      input logic [FFT_CHANNELS*FFT_SAMPLE_W-1:0] samples
   );
      logic [FFT_CHANNELS*2*FFT_SAMPLE_W-1:0] beat;
      beat = '0;
      for (int k = 0; k < FFT_CHANNELS; k++) begin
         beat[k*2*FFT_SAMPLE_W +: FFT_SAMPLE_W] = samples[k*FFT_SAMPLE_W +: FFT_SAMPLE_W];
      end
      return beat;
   endfunction

endpackage

// File: rtl/fft_frame_sequencer_out_reg.sv
// One-entry AXI-stream holding register feeding the FFT input; a new beat may
// be loaded in the same cycle the held beat is consumed.
module fft_seq_out_reg
   import fft_seq_pkg::*;
#(
   parameter int DATA_W = FFT_CHANNELS*2*FFT_SAMPLE_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              last_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              last_o
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic              last_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         last_q  <= last_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames the 4-channel sample stream for the FFT, issues the FFT config word
// and bounds frames in flight. FFT_SEQ_OVERRUN_CNT_EN enables drop counting.
module fft_frame_sequencer
   import fft_seq_pkg::*;
#(
   parameter int FRAME_LEN    = FFT_FRAME_LEN,
   parameter int SAMPLE_W     = FFT_SAMPLE_W,
   parameter int CHANNELS     = FFT_CHANNELS,
   parameter int CFG_W        = FFT_CFG_W,
   parameter int MAX_INFLIGHT = 2
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic [CHANNELS*SAMPLE_W-1:0]   sample_data_in,
   input  logic                           sample_valid_in,
   output logic [$clog2(FRAME_LEN)-1:0]   sample_index_out,
   input  logic                           enable_in,
   output logic [CHANNELS*2*SAMPLE_W-1:0] fft_tdata_out,
   output logic                           fft_tvalid_out,
   output logic                           fft_tlast_out,
   input  logic                           fft_tready_in,
   input  logic [CFG_W-1:0]               cfg_word_in,
   input  logic                           cfg_update_in,
   output logic [CFG_W-1:0]               cfg_tdata_out,
   output logic                           cfg_tvalid_out,
   input  logic                           cfg_tready_in,
   input  logic                           res_valid_in,
   input  logic                           res_ready_in,
   input  logic                           res_last_in,
   output logic                           frame_done_out,
   output logic                           busy_out,
   output logic                           overrun_out,
   output logic [15:0]                    overrun_count_out
);

   localparam int IDX_W = $clog2(FRAME_LEN);
   localparam int FLT_W = $clog2(MAX_INFLIGHT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
   localparam logic [FLT_W-1:0] MAX_FLT  = FLT_W'(MAX_INFLIGHT);

   fft_seq_state_t   state_q, state_d;
   logic             started_q;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [FLT_W-1:0] inflight_q, inflight_d;
   logic [CFG_W-1:0] cfgLatch_q, cfgOut_q;
   logic             cfgPending_q;
   logic             frameDone_q;
   logic             outValid, outLast, canAccept, accept;
   logic             tlastHs, resLastHs, cfgHs, enterCfg;

   assign canAccept = !outValid || fft_tready_in;
   assign tlastHs   = outValid && outLast && fft_tready_in;
   assign resLastHs = res_valid_in && res_ready_in && res_last_in;
   assign cfgHs     = cfg_tvalid_out && cfg_tready_in;
   assign enterCfg  = (state_q == DRAIN) && (state_d == CFG);

   // started_q keeps every output low while reset is held and for the release edge.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q   <= CFG;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         started_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CFG:   if (cfgHs) state_d = ARM;
         ARM:   if (enable_in && sample_valid_in) state_d = FILL;
         FILL: begin
            if (tlastHs) begin
               if (cfgPending_q)              state_d = DRAIN;
               else if (inflight_d >= MAX_FLT) state_d = WAIT;
               else if (!enable_in)           state_d = ARM;
               else                           state_d = FILL;
            end
         end
         WAIT:  if (inflight_q < MAX_FLT) state_d = enable_in ? FILL : ARM;
         DRAIN: if (inflight_q == '0) state_d = CFG;
         default: state_d = CFG;
      endcase
   end

   // A sample coinciding with the tlast handshake opens the next frame only if we stay in FILL.
   always_comb begin
      cfg_tvalid_out = 1'b0;
      accept         = 1'b0;
      busy_out       = started_q && (state_q != ARM);
      case (state_q)
         CFG:  cfg_tvalid_out = started_q;
         ARM:  accept = enable_in && sample_valid_in && canAccept;
         FILL: accept = sample_valid_in && canAccept && (!tlastHs || state_d == FILL);
         default: ;
      endcase
   end

   always_comb begin
      inflight_d = inflight_q;
      if (tlastHs && !resLastHs) begin
         inflight_d = inflight_q + 1'b1;
      end else if (!tlastHs && resLastHs && inflight_q != '0) begin
         inflight_d = inflight_q - 1'b1;
      end
      idx_d = accept ? idx_q + 1'b1 : idx_q;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         idx_q        <= '0;
         inflight_q   <= '0;
         frameDone_q  <= 1'b0;
         cfgLatch_q   <= FFT_CFG_DEFAULT;
         cfgOut_q     <= FFT_CFG_DEFAULT;
         cfgPending_q <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         inflight_q  <= inflight_d;
         frameDone_q <= tlastHs;
         if (cfg_update_in) cfgLatch_q <= cfg_word_in;
         if (enterCfg)      cfgOut_q   <= cfgLatch_q;
         if (cfg_update_in) begin
            cfgPending_q <= 1'b1;
         end else if (enterCfg) begin
            cfgPending_q <= 1'b0;
         end
      end
   end

   fft_seq_out_reg #(
      .DATA_W(CHANNELS*2*SAMPLE_W)
   ) u_outReg (
      .clk_i   (clk_in),
      .rst_ni  (rst_in),
      .load_i  (accept),
      .data_i  (packZeroImag(sample_data_in)),
      .last_i  (idx_q == LAST_IDX),
      .ready_i (fft_tready_in),
      .valid_o (outValid),
      .data_o  (fft_tdata_out),
      .last_o  (outLast)
   );

   assign fft_tvalid_out   = outValid;
   assign fft_tlast_out    = outLast;
   assign sample_index_out = idx_q;
   assign cfg_tdata_out    = cfgOut_q;
   assign frame_done_out   = frameDone_q;

`ifdef FFT_SEQ_OVERRUN_CNT_EN
   logic        drop;
   logic        overrun_q;
   logic [15:0] overrunCnt_q;

   assign drop = (state_q == FILL) && sample_valid_in && !canAccept;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         overrun_q    <= 1'b0;
         overrunCnt_q <= '0;
      end else if (drop) begin
         overrun_q <= 1'b1;
         if (overrunCnt_q != 16'hFFFF) overrunCnt_q <= overrunCnt_q + 16'd1;
      end
   end

   assign overrun_out       = overrun_q;
   assign overrun_count_out = overrunCnt_q;
`else
   assign overrun_out       = 1'b0;
   assign overrun_count_out = '0;
`endif

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Sequences the four-channel microphone sample stream into fixed-length frames for the streaming FFT core. Drives the FFT input AXI-stream, including the zero imaginary interleave and `tlast`. Issues the FFT configuration word after reset and on request, applying it only at frame boundaries. Bounds the number of frames in flight through the FFT/localizer path and counts samples dropped under backpressure. Sits between the hanning window and the FFT core.

## Interface
- `FRAME_LEN`, 512: samples per frame; power of two.
- `SAMPLE_W`, 16: bits per real sample.
- `CHANNELS`, 4: microphone channels per beat.
- `CFG_W`, 16: FFT config word width.
- `MAX_INFLIGHT`, 2: maximum frames sent to the FFT whose output `tlast` has not yet been seen.

Ports:
- `clk_in` input 1: single clock, all logic.
- `rst_in` input 1: reset, asynchronous, active-low.
- `sample_data_in` input CHANNELS*SAMPLE_W: windowed samples; channel 0 in the LSBs.
- `sample_valid_in` input 1: one-cycle sample strobe; the source cannot stall.
- `sample_index_out` output $clog2(FRAME_LEN): index the next accepted sample will take; feeds the window.
- `enable_in` input 1: start new frames while high.
- `fft_tdata_out` output CHANNELS*2*SAMPLE_W: per channel `{SAMPLE_W'0, sample}`.
- `fft_tvalid_out` output 1, `fft_tlast_out` output 1, `fft_tready_in` input 1: FFT input stream.
- `cfg_word_in` input CFG_W, `cfg_update_in` input 1: new config word and one-cycle update request.
- `cfg_tdata_out` output CFG_W, `cfg_tvalid_out` output 1, `cfg_tready_in` input 1: FFT config stream.
- `res_valid_in` input 1, `res_ready_in` input 1, `res_last_in` input 1: observed FFT output handshake.
- `frame_done_out` output 1: one-cycle pulse on the input `tlast` handshake.
- `busy_out` output 1: high in every state except ARM.
- `overrun_out` output 1: sticky drop flag.
- `overrun_count_out` output 16: count of dropped samples; saturates.

## Operation
- States: CFG, ARM, FILL, WAIT, DRAIN.
- **CFG:** `cfg_tdata_out` holds the latched word and `cfg_tvalid_out` is 1. On `cfg_tvalid_out && cfg_tready_in`, go to ARM.
- **ARM:** if `enable_in && sample_valid_in`, accept the sample as index 0 and go to FILL.
- **FILL:** each `sample_valid_in` is accepted if the output register is empty or `fft_tready_in` is 1.
  - On acceptance, the index increments modulo FRAME_LEN.
  - Otherwise the sample is dropped, the index does not advance, and the overrun logic updates.
- The sample at index FRAME_LEN-1 is loaded with `fft_tlast_out`=1. On the tlast handshake, the next state is chosen in priority order:
  - DRAIN if a config update is pending;
  - WAIT if in-flight == MAX_INFLIGHT;
  - ARM if `!enable_in`;
  - FILL otherwise.
- **WAIT:** samples are ignored and are not counted as overruns. Leave when in-flight < MAX_INFLIGHT, to ARM if `!enable_in`, else to FILL.
- **DRAIN:** samples are ignored. When in-flight == 0, go to CFG.
- In-flight counter:
  - increments on the input tlast handshake;
  - decrements on `res_valid_in && res_ready_in && res_last_in`;
  - if both events occur in the same cycle, the count is unchanged.
- `cfg_update_in` latches `cfg_word_in` and sets pending; a later update overwrites the latched word. Entering CFG clears pending. An update arriving in CFG is held for the next boundary.
- `enable_in` falling mid-frame: the frame completes.
- The FFT config port uses the dedicated config stream handshake only.

## Timing
- Reset values:
  - state CFG;
  - latched cfg word = 0;
  - every output 0 (`sample_index_out`=0);
  - `busy_out`=1 once the state is readable.
- `cfg_tvalid_out` rises on the first clock edge after reset release.
- The output stage is a one-entry register:
  - a sample accepted at edge N appears on `fft_tvalid_out` after edge N;
  - `fft_tvalid_out` is held with stable data until `fft_tready_in`;
  - acceptance and transfer may occur in the same cycle, sustaining one beat per cycle.
- `frame_done_out` is asserted the cycle after the tlast handshake.
- Overrun flag and counter update one cycle after the drop.
- Reset mid-frame clears everything; the partial frame is abandoned and the FFT core must be reset alongside.

## Configuration
- `FFT_SEQ_OVERRUN_CNT_EN` defined: `overrun_out` and the saturating 16-bit `overrun_count_out` are implemented.
- Not defined: both outputs are tied to 0, no counter registers exist, and drops still occur silently.

## Structure
- Shared package `fft_seq_pkg`:
  - state enum `fft_seq_state_t`;
  - `FFT_FRAME_LEN` = 512;
  - `FFT_CFG_DEFAULT`;
  - helper function packing `{zero, sample}` per channel.
- One sub-module, `fft_seq_out_reg`: the one-entry AXI-stream output register with tdata/tlast. The FSM, counters and config logic stay in the top module.

## Test plan
- **Config after reset.** Release reset with `cfg_tready_in` low for 5 cycles. Required: `cfg_tvalid_out` high for all 5 cycles with data 0, then the state reaches ARM; no FFT beats are sent before the handshake.
- **Full frame, tready always 1.** Feed 512 strobes. Required: 512 beats with channel k sample in bits [32k+15:32k] and upper bits 0; `tlast` on beat 512 only; a single `frame_done_out` pulse.
- **Backpressure.** With the output register full, hold `fft_tready_in` low across 3 strobes. Required: 3 drops and `overrun_count_out`=3; the frame still ends after 512 accepted samples.
- **In-flight bound.** Send 2 frames with no result `tlast`. Required: the state goes to WAIT and samples are ignored. One `res_last_in` handshake resumes FILL on the next strobe.
- **Config update.** Pulse `cfg_update_in` with 16'h0155 mid-frame. Required: the current frame completes, the state goes to DRAIN until in-flight is 0, then CFG presents 16'h0155 on `cfg_tdata_out`.
- **Reset mid-frame.** Assert reset after 200 samples. Required: all outputs 0 immediately, and `cfg_tvalid_out` again on the first edge after release.
